ddr3_pattern_tester: RTL and testbench

Initiator for the DDR3 x16 controller local user interface: after a `start` pulse it runs controller init, writes a deterministic pattern over a region, reads it back, and compares every beat. It sits in the 125 MHz `clk` domain beside the PCIe core and drives the `ddr3_x16_*` local ports that are otherwise tied off. Results are reported on status outputs for GPIO/LED or a later PCIe register file.

---
 rtl/ddr3_pattern_tester.sv | 202 ++++++++++++++++++++
 tb/tb_ddr3_pattern_tester.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_pattern_tester.sv
// Pattern initiator for the DDR3 x16 local user interface: init, write a
// {~b, b} beat pattern over a region, read it back and count mismatching beats.
module ddr3_pattern_tester #(
    parameter int unsigned NUM_CMDS  = 256,
    parameter logic [25:0] BASE_ADDR = 26'd0,
    parameter logic [23:0] TIMEOUT   = 24'd1000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic        init_start,
    input  logic        init_done,
    output logic [3:0]  cmd,
    output logic        cmd_valid,
    input  logic        cmd_rdy,
    output logic [25:0] addr,
    output logic [4:0]  cmd_burst_cnt,
    output logic        ofly_burst_len,
    output logic [63:0] write_data,
    output logic [7:0]  data_mask,
    input  logic        datain_rdy,
    input  logic [63:0] read_data,
    input  logic        read_data_valid,
    input  logic        wl_err,
    output logic        busy,
    output logic        pass,
    output logic        fail,
    output logic [15:0] err_count,
    output logic [25:0] first_err_addr,
    output logic [2:0]  dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_WR_CMD  = 3'd2,
        S_WR_DATA = 3'd3,
        S_RD_CMD  = 3'd4,
        S_RD_DATA = 3'd5,
        S_DONE    = 3'd6,
        S_FAIL    = 3'd7
    } state_t;

    localparam logic [3:0]  CMD_READ    = 4'b0001;
    localparam logic [3:0]  CMD_WRITE   = 4'b0010;
    localparam logic [15:0] LAST_CMD    = 16'(NUM_CMDS - 1);
    localparam logic [16:0] TOTAL_BEATS = 17'(2 * NUM_CMDS);

    function automatic logic [63:0] pattern(input logic [16:0] beat);
        logic [31:0] w;
        w = 32'(beat);
        return {~w, w};
    endfunction

    function automatic logic [25:0] cmd_addr(input logic [15:0] idx);
        return BASE_ADDR + {7'd0, idx, 3'd0};
    endfunction

    state_t      state_q, state_d;
    logic [15:0] c_q, c_d;
    logic [16:0] b_q, b_d, rb_q, rb_d;
    logic [23:0] wd_q, wd_d;
    logic [15:0] err_count_q, err_count_d;
    logic [25:0] first_err_addr_q, first_err_addr_d;
    logic        init_start_q, init_start_d;
    logic [3:0]  cmd_q, cmd_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [25:0] addr_q, addr_d;
    logic [63:0] write_data_q, write_data_d;
    logic        busy_q, busy_d, pass_q, pass_d, fail_q, fail_d;
    logic        running, progress;

    // Handshakes: a command transfers on a cycle with cmd_valid && cmd_rdy; cmd and
    // addr hold until then. A write beat transfers on each datain_rdy cycle in
    // WR_DATA and a read beat on each read_data_valid cycle; both have no back-pressure.
    always_comb begin
        state_d          = state_q;
        c_d              = c_q;
        b_d              = b_q;
        rb_d             = rb_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        progress         = 1'b0;
        running          = (state_q inside {S_INIT, S_WR_CMD, S_WR_DATA, S_RD_CMD, S_RD_DATA});

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    state_d          = S_INIT;
                    c_d              = '0;
                    b_d              = '0;
                    rb_d             = '0;
                    err_count_d      = '0;
                    first_err_addr_d = '0;
                end
            end
            S_INIT: if (init_done) state_d = S_WR_CMD;
            S_WR_CMD: if (cmd_valid_q && cmd_rdy) state_d = S_WR_DATA;
            S_WR_DATA: begin
                if (datain_rdy) begin
                    progress = 1'b1;
                    b_d      = b_q + 17'd1;
                    // b is even at the start of every command, so an odd b is its 2nd beat
                    if (b_q[0]) begin
                        if (c_q == LAST_CMD) begin
                            c_d     = '0;
                            b_d     = '0;
                            state_d = S_RD_CMD;
                        end else begin
                            c_d     = c_q + 16'd1;
                            state_d = S_WR_CMD;
                        end
                    end
                end
            end
            S_RD_CMD: begin
                if (cmd_valid_q && cmd_rdy) begin
                    progress = 1'b1;
                    if (c_q == LAST_CMD) state_d = S_RD_DATA;
                    else c_d = c_q + 16'd1;
                end
            end
            default: ;
        endcase

        if ((state_q == S_RD_CMD || state_q == S_RD_DATA) && read_data_valid) begin
            progress = 1'b1;
            rb_d     = rb_q + 17'd1;
            if (read_data != pattern(rb_q)) begin
                if (err_count_q == 16'd0) first_err_addr_d = cmd_addr(rb_q[16:1]);
                if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            end
            if (rb_d == TOTAL_BEATS) state_d = (err_count_d == 16'd0) ? S_DONE : S_FAIL;
        end

        if (running && (wl_err || wd_q == TIMEOUT)) state_d = S_FAIL;

        if (!running || state_d != state_q || progress) wd_d = '0;
        else wd_d = wd_q + 24'd1;

        // Outputs are registered from the next state so they line up with it
        init_start_d = (state_d == S_INIT);
        cmd_valid_d  = (state_d == S_WR_CMD) || (state_d == S_RD_CMD);
        cmd_d        = (state_d == S_WR_CMD) ? CMD_WRITE :
                       (state_d == S_RD_CMD) ? CMD_READ : 4'b0000;
        addr_d       = cmd_valid_d ? cmd_addr(c_d) : 26'd0;
        write_data_d = (state_d == S_WR_CMD || state_d == S_WR_DATA) ? pattern(b_d) : 64'd0;
        busy_d       = (state_d inside {S_INIT, S_WR_CMD, S_WR_DATA, S_RD_CMD, S_RD_DATA});
        pass_d       = (state_d == S_DONE);
        fail_d       = (state_d == S_FAIL);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q          <= S_IDLE;
            c_q              <= '0;
            b_q              <= '0;
            rb_q             <= '0;
            wd_q             <= '0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            init_start_q     <= 1'b0;
            cmd_q            <= '0;
            cmd_valid_q      <= 1'b0;
            addr_q           <= '0;
            write_data_q     <= '0;
            busy_q           <= 1'b0;
            pass_q           <= 1'b0;
            fail_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            c_q              <= c_d;
            b_q              <= b_d;
            rb_q             <= rb_d;
            wd_q             <= wd_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            init_start_q     <= init_start_d;
            cmd_q            <= cmd_d;
            cmd_valid_q      <= cmd_valid_d;
            addr_q           <= addr_d;
            write_data_q     <= write_data_d;
            busy_q           <= busy_d;
            pass_q           <= pass_d;
            fail_q           <= fail_d;
        end
    end

    assign init_start     = init_start_q;
    assign cmd            = cmd_q;
    assign cmd_valid      = cmd_valid_q;
    assign addr           = addr_q;
    assign cmd_burst_cnt  = 5'd1;
    assign ofly_burst_len = 1'b0;
    assign write_data     = write_data_q;
    assign data_mask      = 8'd0;
    assign busy           = busy_q;
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_ddr3_pattern_tester.sv
// Bench for ddr3_pattern_tester: a behavioural DDR3 local-port model with a
// beat memory, optional random stalls, read corruption and fault injection.
module tb_ddr3_pattern_tester;
    localparam int          N        = 4;
    localparam logic [25:0] TB_BASE  = 26'd0;
    localparam int          TB_TMO   = 100;
    localparam int          FLIP_IDX = 5;

    logic        clk = 1'b0;
    logic        rstn, start, init_done, cmd_rdy, datain_rdy, read_data_valid, wl_err;
    logic [63:0] read_data;
    logic        init_start, cmd_valid, ofly_burst_len, busy, pass, fail;
    logic [3:0]  cmd;
    logic [25:0] addr, first_err_addr;
    logic [4:0]  cmd_burst_cnt;
    logic [63:0] write_data;
    logic [7:0]  data_mask;
    logic [15:0] err_count;
    logic [2:0]  dbg_state;

    always #4 clk = ~clk;

    ddr3_pattern_tester #(
        .NUM_CMDS (N),
        .BASE_ADDR(TB_BASE),
        .TIMEOUT  (24'(TB_TMO))
    ) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .init_start(init_start), .init_done(init_done),
        .cmd(cmd), .cmd_valid(cmd_valid), .cmd_rdy(cmd_rdy), .addr(addr),
        .cmd_burst_cnt(cmd_burst_cnt), .ofly_burst_len(ofly_burst_len),
        .write_data(write_data), .data_mask(data_mask), .datain_rdy(datain_rdy),
        .read_data(read_data), .read_data_valid(read_data_valid), .wl_err(wl_err),
        .busy(busy), .pass(pass), .fail(fail), .err_count(err_count),
        .first_err_addr(first_err_addr), .dbg_state(dbg_state)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Memory model and scoreboard state
    logic [63:0] mem [int];
    logic [63:0] exp_wd_q[$];
    logic [25:0] exp_wa_q[$];
    logic [25:0] exp_ra_q[$];
    logic [63:0] rd_q[$];
    logic        init_en, stall_en, hold_data, hold_rd, flip_en;
    int          init_cnt, wr_pending, wr_k, wr_cmds, rd_cmds, wr_beats, rd_push_idx;
    logic [25:0] cur_wr_addr, prev_addr;
    logic [63:0] prev_wd;
    logic        prev_cmd_stall, prev_wd_stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_beat(input int i);
        logic [31:0] w;
        w = i[31:0];
        return {~w, w};
    endfunction

    task automatic drop_pending();
        wr_pending     = 0;
        prev_cmd_stall = 1'b0;
        prev_wd_stall  = 1'b0;
        rd_q.delete();
    endtask

    task automatic clear_model();
        mem.delete();
        exp_wd_q.delete();
        exp_wa_q.delete();
        exp_ra_q.delete();
        drop_pending();
        init_cnt = 0; wr_k = 0; wr_cmds = 0; rd_cmds = 0; wr_beats = 0; rd_push_idx = 0;
        for (int i = 0; i < 2 * N; i++) exp_wd_q.push_back(exp_beat(i));
        for (int c = 0; c < N; c++) begin
            exp_wa_q.push_back(26'(TB_BASE + 26'(8 * c)));
            exp_ra_q.push_back(26'(TB_BASE + 26'(8 * c)));
        end
    endtask

    // One cycle of the controller model: inputs change at the falling edge and the
    // transfers they imply are scored against the outputs stable at that moment.
    task automatic tick();
        logic [63:0] d;
        int          key;
        @(negedge clk);
        if (prev_cmd_stall) begin
            check("cmd_hold_valid", 64'(cmd_valid), 64'd1);
            check("cmd_hold_addr", 64'(addr), 64'(prev_addr));
        end
        if (prev_wd_stall) check("wdata_hold", write_data, prev_wd);

        init_done = 1'b0;
        if (init_en && init_start) begin
            if (init_cnt == 2) begin
                init_done = 1'b1;
                init_cnt  = 0;
            end else init_cnt++;
        end else init_cnt = 0;
        cmd_rdy    = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        datain_rdy = (wr_pending > 0) && !hold_data && (!stall_en || $urandom_range(0, 1) == 1);
        if (rd_q.size() > 0 && !hold_rd && (!stall_en || $urandom_range(0, 1) == 1)) begin
            read_data_valid = 1'b1;
            read_data       = rd_q.pop_front();
        end else begin
            read_data_valid = 1'b0;
            read_data       = {$urandom, $urandom};
        end

        prev_cmd_stall = cmd_valid && !cmd_rdy;
        prev_addr      = addr;
        prev_wd_stall  = (wr_pending > 0) && !datain_rdy;
        prev_wd        = write_data;

        if (datain_rdy) begin
            wr_beats++;
            check("wdata_expected", 64'(exp_wd_q.size() > 0), 64'd1);
            if (exp_wd_q.size() > 0) check("wdata", write_data, exp_wd_q.pop_front());
            mem[int'(cur_wr_addr) + wr_k] = write_data;
            wr_k++;
            wr_pending--;
        end
        if (cmd_valid && cmd_rdy) begin
            if (cmd == 4'b0010) begin
                wr_cmds++;
                check("wr_cmd_expected", 64'(exp_wa_q.size() > 0), 64'd1);
                if (exp_wa_q.size() > 0) check("wr_cmd_addr", 64'(addr), 64'(exp_wa_q.pop_front()));
                cur_wr_addr = addr;
                wr_pending  = 2;
                wr_k        = 0;
            end else if (cmd == 4'b0001) begin
                rd_cmds++;
                check("rd_cmd_expected", 64'(exp_ra_q.size() > 0), 64'd1);
                if (exp_ra_q.size() > 0) check("rd_cmd_addr", 64'(addr), 64'(exp_ra_q.pop_front()));
                for (int k = 0; k < 2; k++) begin
                    key = int'(addr) + k;
                    d   = mem.exists(key) ? mem[key] : 64'd0;
                    if (flip_en && rd_push_idx == FLIP_IDX) d[0] = ~d[0];
                    rd_q.push_back(d);
                    rd_push_idx++;
                end
            end else check("cmd_code", 64'(cmd), 64'd1);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_init_start", 64'(init_start), 64'd1);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic check_clean_pass(input string tag);
        check({tag, "_pass"}, 64'(pass), 64'd1);
        check({tag, "_fail"}, 64'(fail), 64'd0);
        check({tag, "_err_count"}, 64'(err_count), 64'd0);
        check({tag, "_first_err_addr"}, 64'(first_err_addr), 64'd0);
        check({tag, "_wr_beats"}, 64'(wr_beats), 64'(2 * N));
        check({tag, "_wr_cmds"}, 64'(wr_cmds), 64'(N));
        check({tag, "_rd_cmds"}, 64'(rd_cmds), 64'(N));
        check({tag, "_rd_drained"}, 64'(rd_q.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_init_start"}, 64'(init_start), 64'd0);
        check({tag, "_cmd"}, 64'(cmd), 64'd0);
        check({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        check({tag, "_addr"}, 64'(addr), 64'd0);
        check({tag, "_write_data"}, write_data, 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_pass"}, 64'(pass), 64'd0);
        check({tag, "_fail"}, 64'(fail), 64'd0);
        check({tag, "_err_count"}, 64'(err_count), 64'd0);
        check({tag, "_first_err_addr"}, 64'(first_err_addr), 64'd0);
    endtask

    initial begin
        int n;
        rstn = 1'b0; start = 1'b0; wl_err = 1'b0; init_done = 1'b0;
        cmd_rdy = 1'b0; datain_rdy = 1'b0; read_data_valid = 1'b0; read_data = '0;
        init_en = 1'b1; stall_en = 1'b0; hold_data = 1'b0; hold_rd = 1'b0; flip_en = 1'b0;
        clear_model();
        repeat (3) tick();
        rstn = 1'b1;
        check_idle_outputs("reset");
        check("reset_burst_cnt", 64'(cmd_burst_cnt), 64'd1);
        check("reset_ofly", 64'(ofly_burst_len), 64'd0);
        check("reset_mask", 64'(data_mask), 64'd0);

        // Ideal controller: always ready, data echoed
        clear_model();
        pulse_start();
        wait_done("ideal_done", 1000);
        check_clean_pass("ideal");

        // Corrupt bit 0 of read beat 5
        clear_model();
        flip_en = 1'b1;
        pulse_start();
        wait_done("flip_done", 1000);
        flip_en = 1'b0;
        check("flip_fail", 64'(fail), 64'd1);
        check("flip_pass", 64'(pass), 64'd0);
        check("flip_err_count", 64'(err_count), 64'd1);
        check("flip_first_err_addr", 64'(first_err_addr), 64'(TB_BASE + 26'(8 * (FLIP_IDX / 2))));

        // Random stalls on cmd_rdy, datain_rdy and read returns
        clear_model();
        stall_en = 1'b1;
        pulse_start();
        wait_done("stall_done", 3000);
        stall_en = 1'b0;
        check_clean_pass("stall");

        // init_done never arrives: watchdog
        clear_model();
        init_en = 1'b0;
        pulse_start();
        n = 1;
        while (!fail && n < 300) begin
            tick();
            n++;
        end
        init_en = 1'b1;
        check("tmo_latency_window", 64'(n >= TB_TMO && n <= TB_TMO + 2), 64'd1);
        check("tmo_fail", 64'(fail), 64'd1);
        check("tmo_busy", 64'(busy), 64'd0);
        check("tmo_init_start", 64'(init_start), 64'd0);

        // wl_err while waiting for write data
        clear_model();
        hold_data = 1'b1;
        pulse_start();
        n = 0;
        while (wr_cmds == 0 && n < 50) begin
            tick();
            n++;
        end
        check("wl_wr_cmd_seen", 64'(wr_cmds), 64'd1);
        tick();
        drop_pending();
        wl_err = 1'b1;
        tick();
        wl_err = 1'b0;
        hold_data = 1'b0;
        check("wl_fail", 64'(fail), 64'd1);
        check("wl_busy", 64'(busy), 64'd0);
        check("wl_pass", 64'(pass), 64'd0);
        check("wl_cmd_valid", 64'(cmd_valid), 64'd0);

        // Reset while read data is outstanding, then a clean rerun
        clear_model();
        hold_rd = 1'b1;
        pulse_start();
        n = 0;
        while (rd_cmds < N && n < 200) begin
            tick();
            n++;
        end
        check("rst_rd_cmds_seen", 64'(rd_cmds), 64'(N));
        tick();
        drop_pending();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        hold_rd = 1'b0;
        check_idle_outputs("midrst");
        clear_model();
        pulse_start();
        wait_done("rerun_done", 1000);
        check_clean_pass("rerun");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end
endmodule
